// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and limits for the memory bus arbiter.
package memory_bus_arbiter_pkg;

  localparam int MEM_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_picker
  import memory_bus_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  // Rotating the doubled vector puts requester ptr at bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    sum   = '0;
    valid = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum   = {1'b0, ptr} + (IDX_W + 1)'(j);
        valid = 1'b1;
      end
    end
    idx = (sum >= N_L) ? IDX_W'(sum - N_L) : sum[IDX_W-1:0];
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among NUM_REQ requesters, one transaction at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int BUS_WIDTH_BYTES = 4,
  parameter int BUS_WIDTH_BITS  = BUS_WIDTH_BYTES * 8,
  parameter int XLEN            = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_read,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*XLEN-1:0]           req_address,
  input  logic [NUM_REQ*BUS_WIDTH_BITS-1:0] req_wdata,
  output logic [BUS_WIDTH_BITS-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                req_done,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [XLEN-1:0]                   mem_address,
  output logic [BUS_WIDTH_BITS-1:0]         mem_wdata,
  input  logic [BUS_WIDTH_BITS-1:0]         mem_rdata,
  input  logic                              mem_ready,
  input  logic                              mem_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > MEM_ARB_MAX_REQ) begin : g_cfg_check
    $error("memory_bus_arbiter: NUM_REQ must be 2..8");
  end

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [XLEN-1:0]           mem_address_q, mem_address_d;
  logic [BUS_WIDTH_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [BUS_WIDTH_BITS-1:0] req_rdata_q, req_rdata_d;
  logic [NUM_REQ-1:0]        req_done_q, req_done_d;

  logic [NUM_REQ-1:0]        req_any;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_vld;
  logic [XLEN-1:0]           addr_a  [NUM_REQ];
  logic [BUS_WIDTH_BITS-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_a[i]  = req_address[i*XLEN +: XLEN];
    assign wdata_a[i] = req_wdata[i*BUS_WIDTH_BITS +: BUS_WIDTH_BITS];
  end

  assign req_any = req_read | req_write;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_any),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] grant_next;

  assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    rr_d = rr_q;
    if (state_q == BUSY && mem_done) rr_d = grant_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_q <= '0;
    else          rr_q <= rr_d;
  end

  assign rr_ptr = rr_q;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    req_rdata_d   = req_rdata_q;
    req_done_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld && mem_ready) begin
          state_d       = BUSY;
          grant_d       = pick_idx;
          // A requester raising both strobes is served as a write.
          mem_write_d   = req_write[pick_idx];
          mem_read_d    = req_read[pick_idx] & ~req_write[pick_idx];
          mem_address_d = addr_a[pick_idx];
          mem_wdata_d   = wdata_a[pick_idx];
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_d     = RELEASE;
          req_done_d  = NUM_REQ'(1) << grant_q;
          if (mem_read_q) req_rdata_d = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      req_rdata_q   <= '0;
      req_done_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      req_rdata_q   <= req_rdata_d;
      req_done_q    <= req_done_d;
    end
  end

  assign req_ready   = (state_q == IDLE) ? {NUM_REQ{1'b1}} : '0;
  assign req_done    = req_done_q;
  assign req_rdata   = req_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter: vector table, corner-case sequences, randomized traffic vs. a transaction model.
`timescale 1ns/1ps
module tb_memory_bus_arbiter;

  localparam int N  = 2;
  localparam int BW = 32;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_read, req_write;
  logic [N*XL-1:0] req_address;
  logic [N*BW-1:0] req_wdata;
  logic [BW-1:0]   req_rdata;
  logic [N-1:0]    req_ready, req_done;
  logic            mem_read, mem_write;
  logic [XL-1:0]   mem_address;
  logic [BW-1:0]   mem_wdata, mem_rdata;
  logic            mem_ready, mem_done;

  memory_bus_arbiter #(.NUM_REQ(N), .BUS_WIDTH_BYTES(4), .XLEN(XL)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read), .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_ready(req_ready), .req_done(req_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model: responds mem_lat cycles after it first sees a strobe, one-cycle mem_done.
  int          mem_lat = 3;
  bit          m_act   = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_resp;
  logic [31:0] next_resp = 32'h0;

  task automatic mem_step();
    if (!reset_n) begin
      m_act    = 1'b0;
      mem_done = 1'b0;
    end else if (mem_done) begin
      mem_done  = 1'b0;
      m_act     = 1'b0;
      mem_rdata = $urandom;
    end else if (m_act) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        mem_done  = 1'b1;
        mem_rdata = m_resp;
      end
    end else if (mem_read || mem_write) begin
      m_act     = 1'b1;
      m_cnt     = mem_lat;
      m_resp    = next_resp;
      next_resp = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_read  = '0;
    req_write = '0;
    mem_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string name, input logic [N-1:0] exp);
    int n = 0;
    while (req_done == '0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, req_done, exp);
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1, d0, d1, resp;
    int          lat;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_done;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [6];

  // Random-phase model state
  bit          m_busy, m_rel, m_isrd, prev_mrdy, prev_done;
  int          m_g, ptr;
  logic [31:0] m_addr, m_wd, exp_rdata, prev_mrdata;
  logic [N-1:0]    prev_rd, prev_wr, exp_done;
  logic [N*XL-1:0] prev_a;
  logic [N*BW-1:0] prev_d;
  logic [31:0]     cexp [4];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    req_read    = '0;
    req_write   = '0;
    req_address = '0;
    req_wdata   = '0;
    mem_ready   = 1'b1;
    mem_done    = 1'b0;
    mem_rdata   = '0;

    tick();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_req_ready", req_ready, 2'b11);
    do_reset();

    vt[0] = '{2'b01, 2'b00, 32'h100, 32'h0, 32'hAAAA0000, 32'h0, 32'hDEADBEEF, 3,
              1'b1, 1'b0, 32'h100, 32'hAAAA0000, 2'b01, 32'hDEADBEEF};
    vt[1] = '{2'b00, 2'b10, 32'h0, 32'h2000, 32'h0, 32'h12345678, 32'h55555555, 2,
              1'b0, 1'b1, 32'h2000, 32'h12345678, 2'b10, 32'hDEADBEEF};
    vt[2] = '{2'b01, 2'b01, 32'h300, 32'h0, 32'hCAFEF00D, 32'h0, 32'h66666666, 1,
              1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 2'b01, 32'hDEADBEEF};
`ifdef MEM_ARB_FIXED_PRIO_EN
    vt[3] = '{2'b11, 2'b00, 32'h400, 32'h404, 32'h11, 32'h22, 32'h0BADC0DE, 2,
              1'b1, 1'b0, 32'h400, 32'h11, 2'b01, 32'h0BADC0DE};
`else
    vt[3] = '{2'b11, 2'b00, 32'h400, 32'h404, 32'h11, 32'h22, 32'h0BADC0DE, 2,
              1'b1, 1'b0, 32'h404, 32'h22, 2'b10, 32'h0BADC0DE};
`endif
    vt[4] = '{2'b00, 2'b11, 32'h500, 32'h504, 32'h33, 32'h44, 32'h77777777, 4,
              1'b0, 1'b1, 32'h500, 32'h33, 2'b01, 32'h0BADC0DE};
    vt[5] = '{2'b10, 2'b00, 32'h0, 32'h600, 32'h0, 32'h99, 32'hFEEDFACE, 1,
              1'b1, 1'b0, 32'h600, 32'h99, 2'b10, 32'hFEEDFACE};

    for (int k = 0; k < 6; k++) begin
      req_address = {vt[k].a1, vt[k].a0};
      req_wdata   = {vt[k].d1, vt[k].d0};
      req_read    = vt[k].rd;
      req_write   = vt[k].wr;
      mem_lat     = vt[k].lat;
      next_resp   = vt[k].resp;
      tick();
      chk($sformatf("vec%0d_mem_read", k), mem_read, vt[k].e_rd);
      chk($sformatf("vec%0d_mem_write", k), mem_write, vt[k].e_wr);
      chk($sformatf("vec%0d_mem_address", k), mem_address, vt[k].e_addr);
      chk($sformatf("vec%0d_mem_wdata", k), mem_wdata, vt[k].e_wdata);
      chk($sformatf("vec%0d_ready_busy", k), req_ready, 2'b00);
      repeat (vt[k].lat) begin
        tick();
        chk($sformatf("vec%0d_early_done", k), req_done, 2'b00);
      end
      tick();
      chk($sformatf("vec%0d_req_done", k), req_done, vt[k].e_done);
      chk($sformatf("vec%0d_req_rdata", k), req_rdata, vt[k].e_rdata);
      chk($sformatf("vec%0d_strobes_clr", k), {mem_read, mem_write}, 2'b00);
      req_read  = '0;
      req_write = '0;
      tick();
      chk($sformatf("vec%0d_done_pulse", k), req_done, 2'b00);
      chk($sformatf("vec%0d_ready_idle", k), req_ready, 2'b11);
    end

    // mem_ready low holds off the grant
    mem_ready   = 1'b0;
    mem_lat     = 2;
    req_address = {32'h0, 32'h700};
    req_read    = 2'b01;
    repeat (5) begin
      tick();
      chk("nordy_strobes", {mem_read, mem_write}, 2'b00);
      chk("nordy_ready", req_ready, 2'b11);
    end
    mem_ready = 1'b1;
    tick();
    chk("nordy_grant_read", mem_read, 1);
    chk("nordy_grant_addr", mem_address, 32'h700);
    wait_done("nordy_done", 2'b01);
    req_read = '0;
    tick();

    // spurious mem_done in IDLE and in RELEASE
    mem_done = 1'b1;
    tick();
    chk("spur_idle_done", req_done, 2'b00);
    chk("spur_idle_strobes", {mem_read, mem_write}, 2'b00);
    mem_lat     = 1;
    req_address = {32'h780, 32'h0};
    req_read    = 2'b10;
    tick();
    chk("spur_rel_grant", mem_read, 1);
    wait_done("spur_rel_done", 2'b10);
    req_read = '0;
    mem_done = 1'b1;
    tick();
    chk("spur_rel_nodone", req_done, 2'b00);
    chk("spur_rel_strobes", {mem_read, mem_write}, 2'b00);
    chk("spur_rel_ready", req_ready, 2'b11);

    // request dropped before the IDLE sample
    mem_ready = 1'b0;
    req_read  = 2'b01;
    tick();
    req_read  = '0;
    mem_ready = 1'b1;
    tick();
    chk("drop_no_grant", {mem_read, mem_write}, 2'b00);
    tick();
    chk("drop_no_grant2", {mem_read, mem_write}, 2'b00);

    // request withdrawn during BUSY still completes
    mem_lat     = 3;
    req_address = {32'h800, 32'h0};
    req_wdata   = {32'hA5A5A5A5, 32'h0};
    req_write   = 2'b10;
    tick();
    chk("wdraw_write", mem_write, 1);
    req_write = '0;
    tick();
    chk("wdraw_held", mem_write, 1);
    chk("wdraw_addr_held", mem_address, 32'h800);
    wait_done("wdraw_done", 2'b10);
    tick();

    // reset while BUSY
    mem_lat     = 20;
    req_address = {32'h0, 32'h900};
    req_read    = 2'b01;
    tick();
    chk("rstbusy_read", mem_read, 1);
    reset_n = 1'b0;
    #1;
    chk("rstbusy_read_clr", mem_read, 0);
    chk("rstbusy_ready", req_ready, 2'b11);
    chk("rstbusy_done", req_done, 2'b00);
    repeat (2) begin
      tick();
      chk("rstbusy_nodone", req_done, 2'b00);
    end
    mem_lat     = 2;
    req_address = {32'h0, 32'hA00};
    reset_n     = 1'b1;
    tick();
    chk("rstbusy_regrant", mem_read, 1);
    chk("rstbusy_regrant_addr", mem_address, 32'hA00);
    wait_done("rstbusy_done2", 2'b01);
    req_read = '0;
    tick();

    // continuous contention
    do_reset();
`ifdef MEM_ARB_FIXED_PRIO_EN
    cexp = '{32'hB00, 32'hB00, 32'hB00, 32'hB00};
`else
    cexp = '{32'hB00, 32'hB04, 32'hB00, 32'hB04};
`endif
    mem_lat     = 1;
    req_address = {32'hB04, 32'hB00};
    req_read    = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      while (!mem_read && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("cont_grant%0d", g), mem_address, cexp[g]);
      wait_done($sformatf("cont_done%0d", g), (cexp[g] == 32'hB00) ? 2'b01 : 2'b10);
    end
    req_read = '0;
    tick();

    // randomized traffic against the transaction model
    do_reset();
    m_busy = 0; m_rel = 0; m_g = 0; ptr = 0; m_isrd = 0;
    m_addr = 0; m_wd = 0; exp_rdata = 0;
    prev_rd = '0; prev_wr = '0; prev_a = '0; prev_d = '0;
    prev_mrdy = mem_ready; prev_done = mem_done; prev_mrdata = mem_rdata;
    for (int c = 0; c < 1500; c++) begin
      tick();
      exp_done = '0;
      if (m_busy) begin
        if (prev_done) begin
          m_busy   = 0;
          m_rel    = 1;
          exp_done = N'(1) << m_g;
          if (m_isrd) exp_rdata = prev_mrdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
          ptr = (m_g + 1) % N;
`endif
        end
      end else if (m_rel) begin
        m_rel = 0;
      end else if (prev_mrdy && (prev_rd | prev_wr) != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          int cand;
          cand = (ptr + k) % N;
          if (prev_rd[cand] | prev_wr[cand]) m_g = cand;
        end
        m_busy = 1;
        m_isrd = !prev_wr[m_g];
        m_addr = prev_a[m_g*XL +: XL];
        m_wd   = prev_d[m_g*BW +: BW];
      end
      chk("rnd_mem_read", mem_read, m_busy & m_isrd);
      chk("rnd_mem_write", mem_write, m_busy & !m_isrd);
      if (m_busy) begin
        chk("rnd_mem_address", mem_address, m_addr);
        chk("rnd_mem_wdata", mem_wdata, m_wd);
      end
      chk("rnd_req_done", req_done, exp_done);
      chk("rnd_req_rdata", req_rdata, exp_rdata);
      chk("rnd_req_ready", req_ready, (m_busy || m_rel) ? 2'b00 : 2'b11);

      for (int i = 0; i < N; i++) begin
        if (req_done[i]) begin
          req_read[i]  = 1'b0;
          req_write[i] = 1'b0;
        end else if (!(req_read[i] | req_write[i]) && $urandom_range(0, 99) < 30) begin
          case ($urandom_range(0, 2))
            0:       begin req_read[i] = 1'b1; req_write[i] = 1'b0; end
            1:       begin req_read[i] = 1'b0; req_write[i] = 1'b1; end
            default: begin req_read[i] = 1'b1; req_write[i] = 1'b1; end
          endcase
          req_address[i*XL +: XL] = $urandom;
          req_wdata[i*BW +: BW]   = $urandom;
        end
      end
      mem_ready   = ($urandom_range(0, 9) != 0);
      mem_lat     = $urandom_range(1, 4);
      prev_rd     = req_read;
      prev_wr     = req_write;
      prev_a      = req_address;
      prev_d      = req_wdata;
      prev_mrdy   = mem_ready;
      prev_done   = mem_done;
      prev_mrdata = mem_rdata;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
